// File: rtl/irq_ctrl.sv
// Interrupt controller slave on the data bus.
// Synchronises raw device requests, latches them as level or edge pending
// bits, masks them with ENABLE and drives one registered request to the CPU.
// Software claims the lowest-numbered pending enabled source via CLAIM.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk_bus,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic [7:0]      bus_address,
  input  logic [31:0]     bus_data_i,
  output logic [31:0]     bus_data_o,
  input  logic            bus_read,
  input  logic            bus_write,
  output logic            irq_out
);

  localparam logic [5:0] RegRaw      = 6'h00;
  localparam logic [5:0] RegPending  = 6'h01;
  localparam logic [5:0] RegEnable   = 6'h02;
  localparam logic [5:0] RegEdge     = 6'h03;
  localparam logic [5:0] RegPolarity = 6'h04;
  localparam logic [5:0] RegClaim    = 6'h05;

  logic [NSRC-1:0] syncFirst_q;
  logic [NSRC-1:0] syncSecond_q;
  logic [NSRC-1:0] prevLvl_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] edgeSel_q;
  logic [NSRC-1:0] polarity_q;
  logic            irq_q;

  logic [5:0]      wordAddr;
  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] claimOneHot;
  logic [NSRC-1:0] claimClr;
  logic [NSRC-1:0] w1cClr;
  logic [4:0]      claimId;
  logic            claimRead;
  logic            unused_bits;

  // The low address bits and write data above NSRC carry no meaning here.
  assign unused_bits = ^{bus_address[1:0], bus_data_i[31:NSRC]};

  assign wordAddr    = bus_address[7:2];
  assign lvl         = syncSecond_q ^ polarity_q;
  assign rise        = lvl & ~prevLvl_q;
  assign active      = pending_q & enable_q;
  assign claimOneHot = active & (~active + 1'b1);
  assign claimRead   = bus_read && (wordAddr == RegClaim);
  assign claimClr    = claimRead ? (claimOneHot & edgeSel_q) : '0;
  assign w1cClr      = (bus_write && (wordAddr == RegPending)) ? bus_data_i[NSRC-1:0] : '0;
  assign irq_out     = irq_q;

  // Lowest-index active source wins; id is reported as index+1, 0 for none.
  always_comb begin
    claimId = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) claimId = 5'(i + 1);
    end
  end

  // Level sources mirror lvl; edge sources set on rising edge, set beats clear.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (edgeSel_q[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~(claimClr[i] | w1cClr[i]));
      end else begin
        pending_d[i] = lvl[i];
      end
    end
  end

  // Two-flop synchroniser, edge history, pending and the combined request.
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      syncFirst_q  <= '0;
      syncSecond_q <= '0;
      prevLvl_q    <= '0;
      pending_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      syncFirst_q  <= irq_src;
      syncSecond_q <= syncFirst_q;
      prevLvl_q    <= lvl;
      pending_q    <= pending_d;
      irq_q        <= |active;
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      enable_q   <= '0;
      edgeSel_q  <= '0;
      polarity_q <= '0;
    end else if (bus_write) begin
      case (wordAddr)
        RegEnable:   enable_q   <= bus_data_i[NSRC-1:0];
        RegEdge:     edgeSel_q  <= bus_data_i[NSRC-1:0];
        RegPolarity: polarity_q <= bus_data_i[NSRC-1:0];
        default:     ;
      endcase
    end
  end

  // Read data is combinational and shows pre-write / pre-clear state.
  always_comb begin
    bus_data_o = 32'd0;
    if (bus_read) begin
      case (wordAddr)
        RegRaw:      bus_data_o = {{(32 - NSRC){1'b0}}, lvl};
        RegPending:  bus_data_o = {{(32 - NSRC){1'b0}}, pending_q};
        RegEnable:   bus_data_o = {{(32 - NSRC){1'b0}}, enable_q};
        RegEdge:     bus_data_o = {{(32 - NSRC){1'b0}}, edgeSel_q};
        RegPolarity: bus_data_o = {{(32 - NSRC){1'b0}}, polarity_q};
        RegClaim:    bus_data_o = {27'd0, claimId};
        default:     bus_data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with an expected-value scoreboard queue.
module tb_irq_ctrl;

  logic        clk_bus;
  logic        rst;
  logic [7:0]  irq_src;
  logic [7:0]  bus_address;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o;
  logic        bus_read;
  logic        bus_write;
  logic        irq_out;

  logic [31:0] expQ[$];
  int          testCount;
  int          failCount;
  logic [31:0] rd;

  irq_ctrl #(.NSRC(8)) dut (
    .clk_bus     (clk_bus),
    .rst         (rst),
    .irq_src     (irq_src),
    .bus_address (bus_address),
    .bus_data_i  (bus_data_i),
    .bus_data_o  (bus_data_o),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .irq_out     (irq_out)
  );

  // Free-running bus clock.
  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_bus);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] src);
    irq_src = src;
  endtask

  task automatic pushExpected(input logic [31:0] value);
    expQ.push_back(value);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    logic [31:0] expected;
    testCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=<none queued>", tag, observed);
    end else begin
      expected = expQ.pop_front();
      assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [31:0] data);
    bus_address = addr;
    bus_read    = 1'b1;
    #1;
    data = bus_data_o;
    @(posedge clk_bus);
    #1;
    bus_read    = 1'b0;
    bus_address = 8'h00;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
    bus_address = addr;
    bus_data_i  = data;
    bus_write   = 1'b1;
    @(posedge clk_bus);
    #1;
    bus_write   = 1'b0;
    bus_address = 8'h00;
    bus_data_i  = 32'd0;
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr, input logic [31:0] value);
    logic [31:0] got;
    pushExpected(value);
    busRead(addr, got);
    checkOutput(tag, got);
  endtask

  task automatic irqCheck(input string tag, input logic value);
    pushExpected({31'd0, value});
    checkOutput(tag, {31'd0, irq_out});
  endtask

  // Directed sequence covering reset, level, edge, claim, W1C and polarity.
  initial begin
    testCount   = 0;
    failCount   = 0;
    rst         = 1'b1;
    irq_src     = 8'hFF;
    bus_address = 8'h00;
    bus_data_i  = 32'd0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    tick(3);

    irqCheck("rst_irq", 1'b0);
    readCheck("rst_raw", 8'h00, 32'h0);
    readCheck("rst_pending", 8'h04, 32'h0);
    readCheck("rst_enable", 8'h08, 32'h0);
    readCheck("rst_edge", 8'h0C, 32'h0);
    readCheck("rst_polarity", 8'h10, 32'h0);
    readCheck("rst_claim", 8'h14, 32'h0);

    rst = 1'b0;
    tick(2);
    readCheck("raw_after_release", 8'h00, 32'hFF);
    readCheck("pending_level_all", 8'h04, 32'hFF);
    irqCheck("irq_masked", 1'b0);
    applyStimulus(8'h00);
    tick(4);
    readCheck("pending_idle", 8'h04, 32'h0);

    busWrite(8'h08, 32'h04);
    applyStimulus(8'h04);
    tick(2);
    readCheck("level_pending_early", 8'h04, 32'h0);
    irqCheck("level_irq_t3", 1'b0);
    tick(1);
    irqCheck("level_irq_t4", 1'b1);
    readCheck("level_pending", 8'h04, 32'h04);
    readCheck("level_claim_a", 8'h14, 32'd3);
    readCheck("level_claim_b", 8'h14, 32'd3);
    applyStimulus(8'h00);
    tick(3);
    irqCheck("level_drop_t3", 1'b1);
    tick(1);
    irqCheck("level_drop_t4", 1'b0);

    busWrite(8'h0C, 32'h01);
    busWrite(8'h08, 32'h01);
    applyStimulus(8'h01);
    tick(3);
    applyStimulus(8'h00);
    tick(6);
    readCheck("edge_latched", 8'h04, 32'h01);
    irqCheck("edge_irq", 1'b1);
    readCheck("edge_claim_1", 8'h14, 32'd1);
    irqCheck("edge_irq_after_claim", 1'b1);
    readCheck("edge_claim_2", 8'h14, 32'd0);
    irqCheck("edge_irq_fall", 1'b0);

    busWrite(8'h0C, 32'hFF);
    busWrite(8'h08, 32'hFF);
    applyStimulus(8'h22);
    tick(2);
    applyStimulus(8'h00);
    tick(5);
    readCheck("prio_claim_a", 8'h14, 32'd2);
    readCheck("prio_claim_b", 8'h14, 32'd6);
    readCheck("prio_claim_c", 8'h14, 32'd0);

    applyStimulus(8'h08);
    tick(2);
    applyStimulus(8'h00);
    tick(5);
    readCheck("w1c_setup", 8'h04, 32'h08);
    applyStimulus(8'h08);
    tick(2);
    busWrite(8'h04, 32'h08);
    readCheck("w1c_set_wins", 8'h04, 32'h08);
    applyStimulus(8'h00);
    tick(4);
    busWrite(8'h04, 32'h08);
    readCheck("w1c_clears", 8'h04, 32'h0);

    busWrite(8'h0C, 32'h00);
    applyStimulus(8'h40);
    tick(4);
    busWrite(8'h04, 32'h40);
    readCheck("w1c_level_kept", 8'h04, 32'h40);
    readCheck("level_claim_7", 8'h14, 32'd7);
    readCheck("level_after_claim", 8'h04, 32'h40);
    applyStimulus(8'h00);
    tick(4);

    busWrite(8'h10, 32'h10);
    tick(2);
    readCheck("polarity_raw", 8'h00, 32'h10);
    readCheck("polarity_reg", 8'h10, 32'h10);
    readCheck("unmapped_read", 8'h40, 32'h0);
    busWrite(8'h40, 32'hFFFF_FFFF);
    readCheck("unmapped_write", 8'h40, 32'h0);
    readCheck("enable_unchanged", 8'h08, 32'hFF);
    busWrite(8'h08, 32'hFFFF_FFFF);
    readCheck("enable_upper_bits", 8'h08, 32'hFF);

    bus_address = 8'h08;
    bus_data_i  = 32'h0F;
    bus_read    = 1'b1;
    bus_write   = 1'b1;
    #1;
    rd = bus_data_o;
    pushExpected(32'hFF);
    checkOutput("rw_collision_read", rd);
    tick(1);
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_data_i  = 32'd0;
    readCheck("rw_collision_write", 8'h08, 32'h0F);

    busWrite(8'h10, 32'h00);
    busWrite(8'h0C, 32'h01);
    busWrite(8'h08, 32'h01);
    applyStimulus(8'h01);
    tick(2);
    applyStimulus(8'h00);
    tick(5);
    irqCheck("pre_reset_irq", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    irqCheck("async_reset_irq", 1'b0);
    bus_address = 8'h04;
    bus_read    = 1'b1;
    #1;
    pushExpected(32'h0);
    checkOutput("async_reset_pending", bus_data_o);
    bus_address = 8'h08;
    #1;
    pushExpected(32'h0);
    checkOutput("async_reset_enable", bus_data_o);
    bus_read    = 1'b0;
    bus_address = 8'h00;

    applyStimulus(8'h01);
    tick(2);
    rst = 1'b0;
    tick(2);
    readCheck("release_pending_early", 8'h04, 32'h0);
    readCheck("release_pending_t3", 8'h04, 32'h01);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
